// File: rtl/seg_capture_if.sv
// Seven-segment capture bus: raw multiplexed display lines in, decoded digit state out.
interface seg_capture_if #(
  parameter int NUM_DIG = 4
);
  logic [7:0]           seg_in;
  logic [NUM_DIG-1:0]   an_in;
  logic [4*NUM_DIG-1:0] value;
  logic [NUM_DIG-1:0]   dp;
  logic [NUM_DIG-1:0]   blank;
  logic [NUM_DIG-1:0]   err;
  logic                 frame_valid;

  modport master (
    output seg_in, an_in,
    input  value, dp, blank, err, frame_valid
  );

  modport slave (
    input  seg_in, an_in,
    output value, dp, blank, err, frame_valid
  );
endinterface

// File: rtl/seg_capture.sv
// Decodes a multiplexed seven-segment bus back into per-digit nibbles after STABLE_CYC stable samples.
// Latency: commit on the STABLE_CYC-th edge of a held pattern; frame_valid registered alongside it.
// Backpressure: none; the display bus is sampled every cycle and cannot be stalled.
module seg_capture #(
  parameter int NUM_DIG    = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic          clk,
  input  logic          rst,
  seg_capture_if.slave  bus
);

  typedef enum logic {TRACK, HELD} state_t;

  state_t               state, state_nxt;
  logic [7:0]           smp_seg;
  logic [NUM_DIG-1:0]   smp_an;
  logic [7:0]           cnt;
  logic [NUM_DIG-1:0]   an_act;
  logic [NUM_DIG-1:0]   mask;
  logic [NUM_DIG-1:0]   mask_upd;
  logic                 chg, reach, one_low, commit;
  logic [3:0]           dec_nib;
  logic                 dec_blank, dec_err;

  logic [4*NUM_DIG-1:0] value_q;
  logic [NUM_DIG-1:0]   dp_q, blank_q, err_q;
  logic                 frame_valid_q;

  assign an_act   = ~bus.an_in;
  assign one_low  = (an_act != '0) && ((an_act & (an_act - 1'b1)) == '0);
  assign chg      = (bus.seg_in != smp_seg) || (bus.an_in != smp_an);
  assign reach    = ({1'b0, cnt} + 9'd1) == 9'(STABLE_CYC);
  assign mask_upd = mask | an_act;

  always_ff @(posedge clk) begin
    if (rst) state <= TRACK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (chg)                        state_nxt = TRACK;
    else if (state == TRACK && reach) state_nxt = HELD;
  end

  // Multi-hot or idle enables still walk TRACK->HELD but never commit.
  always_comb begin
    commit = 1'b0;
    if (!chg && state == TRACK && reach && one_low) commit = 1'b1;
  end

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case ({bus.seg_in[7:1], 1'b1})
      8'h03: dec_nib = 4'h0;
      8'h9F: dec_nib = 4'h1;
      8'h25: dec_nib = 4'h2;
      8'h0D: dec_nib = 4'h3;
      8'h99: dec_nib = 4'h4;
      8'h49: dec_nib = 4'h5;
      8'h41: dec_nib = 4'h6;
      8'h1F: dec_nib = 4'h7;
      8'h01: dec_nib = 4'h8;
      8'h09: dec_nib = 4'h9;
      8'h11: dec_nib = 4'hA;
      8'hC1: dec_nib = 4'hB;
      8'h63: dec_nib = 4'hC;
      8'h85: dec_nib = 4'hD;
      8'h61: dec_nib = 4'hE;
      8'h71: dec_nib = 4'hF;
      8'hFF: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_seg       <= 8'hFF;
      smp_an        <= '1;
      cnt           <= 8'd0;
      mask          <= '0;
      value_q       <= '0;
      dp_q          <= '0;
      blank_q       <= '1;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      if (chg) begin
        smp_seg <= bus.seg_in;
        smp_an  <= bus.an_in;
        cnt     <= 8'd1;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      if (commit) begin
        for (int i = 0; i < NUM_DIG; i++) begin
          if (an_act[i]) begin
            value_q[4*i +: 4] <= dec_nib;
            dp_q[i]           <= ~bus.seg_in[0];
            blank_q[i]        <= dec_blank;
            err_q[i]          <= dec_err;
          end
        end
        if (mask_upd == '1) begin
          frame_valid_q <= 1'b1;
          mask          <= '0;
        end else begin
          mask <= mask_upd;
        end
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.dp          = dp_q;
  assign bus.blank       = blank_q;
  assign bus.err         = err_q;
  assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg_capture.sv
// Randomized + directed bench for seg_capture with a queue-based scoreboard and run-length reference model.
module tb_seg_capture;
  localparam int ND = 4;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_capture_if #(.NUM_DIG(ND)) bus ();

  seg_capture #(.NUM_DIG(ND), .STABLE_CYC(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4*ND-1:0] value;
    logic [ND-1:0]   dp;
    logic [ND-1:0]   blank;
    logic [ND-1:0]   err;
    logic            fv;
  } snap_t;

  snap_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int dut_fv_cnt = 0;

  logic [7:0] dig_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  logic [3:0] an_pool [6] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hC, 4'hF};

  // Reference model: a run length of identical samples plus the set of digits seen.
  snap_t      m;
  logic [7:0] p_seg;
  logic [3:0] p_an;
  int         run;
  logic [3:0] seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_edge(input logic [7:0] s, input logic [3:0] a, input logic r);
    int k;
    int n;
    if (r) begin
      m.value = '0; m.dp = '0; m.blank = '1; m.err = '0; m.fv = 1'b0;
      seen = '0; p_seg = 8'hFF; p_an = 4'hF; run = 0;
    end else begin
      if (s == p_seg && a == p_an) run++;
      else begin
        p_seg = s; p_an = a; run = 1;
      end
      m.fv = 1'b0;
      if (run == SC && $countones(~a) == 1) begin
        k = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) k = i;
        n = -1;
        for (int j = 0; j < 16; j++) if (dig_tab[j][7:1] == s[7:1]) n = j;
        m.dp[k] = ~s[0];
        if (s[7:1] == 7'h7F) begin
          m.value[4*k +: 4] = 4'h0; m.blank[k] = 1'b1; m.err[k] = 1'b0;
        end else if (n < 0) begin
          m.value[4*k +: 4] = 4'h0; m.blank[k] = 1'b0; m.err[k] = 1'b1;
        end else begin
          m.value[4*k +: 4] = n[3:0]; m.blank[k] = 1'b0; m.err[k] = 1'b0;
        end
        seen[k] = 1'b1;
        if (seen == 4'hF) begin
          m.fv = 1'b1;
          seen = '0;
        end
      end
    end
  endtask

  task automatic cyc(input logic [7:0] s, input logic [3:0] a, input logic r);
    rst        = r;
    bus.seg_in = s;
    bus.an_in  = a;
    @(posedge clk);
    model_edge(s, a, r);
    exp_q.push_back(m);
    #2;
  endtask

  task automatic hold(input logic [7:0] s, input logic [3:0] a, input int n);
    repeat (n) cyc(s, a, 1'b0);
  endtask

  // Monitor: every settled cycle is an output beat compared against the queued expectation.
  always @(negedge clk) begin
    snap_t e;
    if (bus.frame_valid === 1'b1) dut_fv_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_value", 32'(bus.value), 32'(e.value));
      chk("sb_dp",    32'(bus.dp),    32'(e.dp));
      chk("sb_blank", 32'(bus.blank), 32'(e.blank));
      chk("sb_err",   32'(bus.err),   32'(e.err));
      chk("sb_fv",    32'(bus.frame_valid), 32'(e.fv));
    end
  end

  initial begin
    int base;
    logic [15:0] v_save;
    logic [3:0]  b_save, e_save, d_save;
    logic [7:0]  s;
    logic [3:0]  a;

    // Reset
    cyc(8'hFF, 4'hF, 1'b1);
    cyc(8'hFF, 4'hF, 1'b1);
    chk("rst_value", 32'(bus.value), 32'h0);
    chk("rst_blank", 32'(bus.blank), 32'hF);
    chk("rst_err",   32'(bus.err),   32'h0);
    chk("rst_dp",    32'(bus.dp),    32'h0);
    chk("rst_fv",    32'(bus.frame_valid), 32'h0);

    // Stability threshold
    hold(8'h25, 4'hE, 3);
    chk("stab_before", 32'(bus.blank[0]), 32'h1);
    hold(8'h25, 4'hE, 1);
    chk("stab_nib", 32'(bus.value[3:0]), 32'h2);
    chk("stab_blank", 32'(bus.blank[0]), 32'h0);
    hold(8'h0D, 4'hE, 3);
    hold(8'hFF, 4'hF, 1);
    chk("short_hold", 32'(bus.value[3:0]), 32'h2);

    // Full frame E D b A
    cyc(8'hFF, 4'hF, 1'b1);
    base = dut_fv_cnt;
    hold(8'h61, 4'h7, 6);
    hold(8'h85, 4'hB, 6);
    hold(8'hC1, 4'hD, 6);
    chk("frame_early", 32'(dut_fv_cnt - base), 32'h0);
    hold(8'h11, 4'hE, 6);
    chk("frame_value", 32'(bus.value), 32'hEDBA);
    chk("frame_pulse", 32'(dut_fv_cnt - base), 32'h1);

    // Decode extremes on digit 1
    hold(8'h00, 4'hD, 5);
    chk("ext8_nib", 32'(bus.value[7:4]), 32'h8);
    chk("ext8_dp",  32'(bus.dp[1]), 32'h1);
    hold(8'hAA, 4'hD, 5);
    chk("extAA_err", 32'(bus.err[1]), 32'h1);
    chk("extAA_nib", 32'(bus.value[7:4]), 32'h0);
    hold(8'hFF, 4'hD, 5);
    chk("extFF_blank", 32'(bus.blank[1]), 32'h1);

    // Invalid enables change nothing
    v_save = bus.value; b_save = bus.blank; e_save = bus.err; d_save = bus.dp;
    hold(8'h03, 4'hC, 10);
    hold(8'h03, 4'hF, 10);
    chk("inv_value", 32'(bus.value), 32'(v_save));
    chk("inv_flags", 32'({bus.blank, bus.err, bus.dp}), 32'({b_save, e_save, d_save}));

    // Long hold commits once; frame needs the other three digits
    cyc(8'hFF, 4'hF, 1'b1);
    base = dut_fv_cnt;
    hold(8'h9F, 4'hE, 20);
    hold(8'h9F, 4'hD, 5);
    hold(8'h9F, 4'hB, 5);
    chk("long_nofv", 32'(dut_fv_cnt - base), 32'h0);
    hold(8'h9F, 4'h7, 5);
    chk("long_fv", 32'(dut_fv_cnt - base), 32'h1);
    chk("long_val", 32'(bus.value), 32'h1111);

    // Mid-frame reset discards the partial frame
    base = dut_fv_cnt;
    hold(8'h49, 4'hE, 5);
    hold(8'h41, 4'hD, 5);
    cyc(8'h41, 4'hD, 1'b1);
    hold(8'h1F, 4'hB, 5);
    hold(8'h01, 4'h7, 5);
    chk("mid_nofv", 32'(dut_fv_cnt - base), 32'h0);
    hold(8'h49, 4'hE, 5);
    hold(8'h41, 4'hD, 5);
    chk("mid_fv", 32'(dut_fv_cnt - base), 32'h1);

    // Randomized segments
    for (int t = 0; t < 300; t++) begin
      int r;
      int ai;
      r = int'($urandom_range(0, 19));
      if (r < 16)       s = dig_tab[r];
      else if (r == 16) s = 8'hFF;
      else if (r == 17) s = 8'hAA;
      else if (r == 18) s = 8'h00;
      else              s = 8'($urandom);
      s[0] = 1'($urandom);
      ai = int'($urandom_range(0, 6));
      a = (ai < 6) ? an_pool[ai] : 4'($urandom);
      if ($urandom_range(0, 49) == 0) cyc(s, a, 1'b1);
      hold(s, a, int'($urandom_range(1, 7)));
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seg_capture.md
# seg_capture

Seven-segment display capture decoder. Samples a multiplexed seven-segment bus (active-low segment byte plus active-low digit enables), waits for each pattern to be stable, decodes it back to a hex nibble, and assembles a multi-digit value. It sits on the observation side of the display path, converting the segment stream produced by the display encoder back into numeric data for self-check and readback.

## Interface
- NUM_DIG, 4: number of multiplexed digits (2..8).
- STABLE_CYC, 4: consecutive identical samples required to accept a pattern (2..255).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- seg_in  in  8  segment byte {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp, 0 = lit.
- an_in  in  NUM_DIG  digit enables, active-low; bit i selects digit i.
- value  out  4*NUM_DIG  decoded nibbles; digit i in value[4i+3:4i].
- dp  out  NUM_DIG  1 = decimal point lit on digit i.
- blank  out  NUM_DIG  1 = digit i last showed all segments off (or not yet seen).
- err  out  NUM_DIG  1 = digit i last showed an undecodable pattern.
- frame_valid  out  1  one-cycle pulse: every digit committed since previous pulse/reset.

## Operation
- Decode table on seg_in[7:1] (dp ignored), listed as full byte with dp=1: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71, blank=FF.
- Unknown pattern: nibble written 0, err[i]=1, blank[i]=0. Known digit: nibble written, err[i]=0, blank[i]=0. Blank: nibble 0, blank[i]=1, err[i]=0. dp[i] <= ~seg_in[0] on every commit.
- Sample register smp holds last {seg_in, an_in}; counter cnt (8 bit) counts consecutive edges with identical pair.
- States: TRACK (counting), HELD (pattern already committed, waiting for change).
- Any edge where {seg_in,an_in} != smp: smp loaded, cnt=1, state TRACK.
- TRACK, pair equal: cnt increments; on the edge where cnt would reach STABLE_CYC: if an_in has exactly one bit low, commit that digit; state HELD regardless of validity (invalid enable = no commit).
- HELD, pair equal: no action, cnt saturates. A re-held identical pattern never commits twice.
- Seen mask (NUM_DIG bits): set bit i on commit of digit i. Edge on which mask becomes all ones: frame_valid=1 next cycle for exactly one cycle, mask cleared in same edge.
- an_in all-high or multiple low: treated as ordinary pair for stability, never commits, never touches mask.

## Timing
- Reset values: value=0, dp=0, blank=all 1, err=0, frame_valid=0, mask=0, cnt=0, smp={8'hFF, all 1}, state TRACK.
- Input applied before edge k and held: smp loaded at k (cnt=1), commit at edge k+STABLE_CYC-1; outputs visible after that edge (STABLE_CYC edges from first sample).
- Pair changing before STABLE_CYC identical edges: nothing committed.
- frame_valid asserted on the same edge as the completing commit's outputs (registered together).
- Reset mid-operation: all state returns to reset values on that edge; partial frames discarded.
- Simultaneous commit of last digit and reset: reset wins.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset: rst=1 two cycles -> value=0x0000, blank=4'hF, err=0, dp=0, frame_valid=0.
- Stability: seg_in=0x25, an_in=4'b1110 held 4 edges -> value[3:0]=2, blank[0]=0 after edge 4; same pair held only 3 edges then changed -> no update.
- Frame: digits 3..0 driven 0x61, 0x85, 0xC1, 0x11, 6 cycles each -> value=0xEDBA, single frame_valid pulse after digit 0 commit, none before.
- Decode extremes: seg_in=0x00 on digit 1 -> nibble 8, dp[1]=1; seg_in=0xAA -> err[1]=1, nibble 0; seg_in=0xFF -> blank[1]=1.
- Invalid enables/hold: an_in=4'b1100 or 4'b1111 held 10 edges -> no output change; valid pattern held 20 edges -> exactly one commit, mask bit set once.
- Mid-frame reset: commit digits 0 and 1, assert rst one cycle, then commit digits 2 and 3 -> no frame_valid until 0 and 1 recommitted.
